// File: rtl/scaler_h_bilinear_if.sv
// Raster video bus for the horizontal bilinear scaler: input side (di/de/hs/vs _i)
// and resampled output side (do/de/hs/vs _o).
interface scaler_h_bilinear_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] di_i;
    logic                   de_i;
    logic                   hs_i;
    logic                   vs_i;
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport master (output di_i, de_i, hs_i, vs_i, input do_o, de_o, hs_o, vs_o);
    modport slave  (input di_i, de_i, hs_i, vs_i, output do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/scaler_h_bilinear.sv
// Streaming horizontal bilinear scaler, one line at a time, 2-cycle latency.
// Optional macro SCALER_H_ROUND_EN: round half up in the final shift instead of truncating.
module scaler_h_bilinear #(
    parameter int LINE_IN_SIZE_MAX = 4096,
    parameter int SCALE_STEP       = 128,
    parameter int PIXEL_WIDTH      = 8,
    parameter int SPARSE_OUT       = 0,
    parameter int COE_WIDTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            reg_h_scale_step,
    input  logic [15:0]            reg_v_scale_step,
    input  logic [15:0]            reg_v_scale_inline_size,
    scaler_h_bilinear_if.slave     vid
);
    localparam int FRAC  = $clog2(SCALE_STEP);
    localparam int NW    = $clog2(LINE_IN_SIZE_MAX + 1);
    localparam int POSW  = (NW + FRAC > 16) ? NW + FRAC : 16;
    localparam int ACCW  = POSW + 1;
    localparam int PRODW = PIXEL_WIDTH + COE_WIDTH;
    localparam int SUMW  = PRODW + 1;
`ifdef SCALER_H_ROUND_EN
    localparam logic [SUMW-1:0] RND_ADD = SUMW'(SCALE_STEP / 2);
`else
    localparam logic [SUMW-1:0] RND_ADD = '0;
`endif

    logic                   unused_bits;
    assign unused_bits = ^{reg_v_scale_step, reg_v_scale_inline_size[15:NW]};

    // line / pair state
    logic                   hs_d;
    logic                   line_act;
    logic [15:0]            step_r;
    logic [NW-1:0]          last_r;
    logic [NW-1:0]          n_in;
    logic [NW-1:0]          n_cur;
    logic [ACCW-1:0]        acc;
    logic [PIXEL_WIDTH-1:0] a_r;
    logic [PIXEL_WIDTH-1:0] b_r;
    logic                   pair_vld;

    // datapath / framing pipeline
    logic                   s1_vld;
    logic [PRODW-1:0]       prod_a;
    logic [PRODW-1:0]       prod_b;
    logic                   hs_p;
    logic                   vs_p;

    logic                   line_start;
    logic [15:0]            step_eff;
    logic [NW-1:0]          last_eff;
    logic [ACCW-1:0]        acc_eff;
    logic [NW-1:0]          n_idx;
    logic                   accept;
    logic [NW-1:0]          cur_n;
    logic                   cur_vld;
    logic [PIXEL_WIDTH-1:0] op_a;
    logic [PIXEL_WIDTH-1:0] op_b;
    logic [ACCW-1:0]        lim;
    logic [ACCW-1:0]        base;
    logic [ACCW-1:0]        c_full;
    logic [COE_WIDTH-1:0]   coe;
    logic [COE_WIDTH-1:0]   coe_inv;
    logic                   emit;
    logic [SUMW-1:0]        sum;
    logic [PIXEL_WIDTH-1:0] pix_next;

    // A line-start cycle sees fresh registers/counters so a pixel on that same cycle is handled.
    always_comb begin
        line_start = hs_d & ~vid.hs_i;
        step_eff   = line_start ? reg_h_scale_step : step_r;
        last_eff   = line_start ? reg_v_scale_inline_size[NW-1:0] : last_r;
        acc_eff    = line_start ? '0 : acc;
        n_idx      = line_start ? '0 : n_in;
        accept     = vid.de_i & ~vid.hs_i & (line_start | line_act) & (n_idx <= last_eff);

        // The first output of a new pair is computed straight from the incoming pixel.
        cur_n      = accept ? n_idx : n_cur;
        cur_vld    = accept ? (n_idx != '0) : (pair_vld & ~line_start);
        op_a       = accept ? b_r : a_r;
        op_b       = accept ? vid.di_i : b_r;

        lim        = ACCW'(cur_n) << FRAC;
        base       = ACCW'(cur_n - NW'(1)) << FRAC;
        emit       = cur_vld & ((acc_eff < lim) | ((cur_n == last_eff) & (acc_eff == lim)));
        c_full     = acc_eff - base;
        coe        = c_full[COE_WIDTH-1:0];
        coe_inv    = COE_WIDTH'(SCALE_STEP) - coe;

        sum        = SUMW'(prod_a) + SUMW'(prod_b) + RND_ADD;
        pix_next   = PIXEL_WIDTH'(sum >> FRAC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d     <= 1'b0;
            line_act <= 1'b0;
            step_r   <= '0;
            last_r   <= '0;
            n_in     <= '0;
            n_cur    <= '0;
            acc      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            pair_vld <= 1'b0;
        end else begin
            hs_d     <= vid.hs_i;
            // hs_d resets low so a reset released mid-line waits for a real falling hs_i.
            line_act <= line_start | (line_act & ~vid.hs_i);
            if (line_start) begin
                step_r   <= reg_h_scale_step;
                last_r   <= reg_v_scale_inline_size[NW-1:0];
                n_in     <= '0;
                pair_vld <= 1'b0;
            end
            if (accept) begin
                a_r      <= b_r;
                b_r      <= vid.di_i;
                n_cur    <= n_idx;
                n_in     <= n_idx + NW'(1);
                pair_vld <= (n_idx != '0);
            end
            if (emit)
                acc <= acc_eff + ACCW'(step_eff);
            else if (line_start)
                acc <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            prod_a   <= '0;
            prod_b   <= '0;
            vid.do_o <= '0;
            vid.de_o <= 1'b0;
            hs_p     <= 1'b1;
            vid.hs_o <= 1'b1;
            vs_p     <= 1'b0;
            vid.vs_o <= 1'b0;
        end else begin
            s1_vld   <= emit;
            prod_a   <= PRODW'(op_a) * PRODW'(coe_inv);
            prod_b   <= PRODW'(op_b) * PRODW'(coe);
            vid.de_o <= s1_vld;
            if (s1_vld)
                vid.do_o <= pix_next;
            else if (SPARSE_OUT == 0)
                vid.do_o <= '0;
            hs_p     <= ~(line_start | (line_act & ~vid.hs_i));
            // Blanking is held off while any output of the line is still in flight.
            vid.hs_o <= hs_p & ~(emit | s1_vld);
            vs_p     <= vid.vs_i;
            vid.vs_o <= vs_p;
        end
    end
endmodule

// File: tb/tb_scaler_h_bilinear.sv
// Directed + randomized line bench for scaler_h_bilinear against a position-based model.
module tb_scaler_h_bilinear;
    localparam int S    = 128;
    localparam int FRAC = 7;
    localparam int PW   = 8;
`ifdef SCALER_H_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] h_step;
    logic [15:0] v_step;
    logic [15:0] last_reg;

    scaler_h_bilinear_if #(.PIXEL_WIDTH(PW)) vid ();

    scaler_h_bilinear #(
        .LINE_IN_SIZE_MAX(4096), .SCALE_STEP(S), .PIXEL_WIDTH(PW),
        .SPARSE_OUT(0), .COE_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_h_scale_step(h_step), .reg_v_scale_step(v_step),
        .reg_v_scale_inline_size(last_reg), .vid(vid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   got[$];
    int   first_de = -1, last_de = -1, hs_fall = -1, hs_rise = -1;
    int   de_in_blank = 0, sparse_bad = 0;
    logic hs_prev = 1'b1;

    always @(negedge clk) begin
        if (vid.de_o === 1'b1) begin
            got.push_back(int'(vid.do_o));
            if (first_de < 0) first_de = cyc;
            last_de = cyc;
            if (vid.hs_o !== 1'b0) de_in_blank++;
        end else if (vid.do_o !== '0) begin
            sparse_bad++;
        end
        if (hs_prev === 1'b1 && vid.hs_o === 1'b0) hs_fall = cyc;
        if (hs_prev === 1'b0 && vid.hs_o === 1'b1) hs_rise = cyc;
        hs_prev = vid.hs_o;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one line and compare against outputs at positions k*step/S of the input line.
    task automatic run_line(input int pix[$], input int step, input int last,
                            input int gap, input string tag);
        int exp_q[$];
        int nout, pos, i, f, v, drv1, fall_drv, rise_drv, rise_exp;
        got.delete();
        first_de = -1; last_de = -1; hs_fall = -1; hs_rise = -1; de_in_blank = 0;
        drv1 = -1;
        h_step = 16'(step);
        last_reg = 16'(last);
        v_step = 16'($urandom);
        step_cyc();
        vid.hs_i = 1'b0;
        fall_drv = cyc;
        step_cyc();
        for (int p = 0; p < pix.size(); p++) begin
            vid.di_i = PW'(pix[p]);
            vid.de_i = 1'b1;
            if (p == 1) drv1 = cyc;
            step_cyc();
            vid.de_i = 1'b0;
            vid.di_i = PW'($urandom);
            for (int g = 1; g < gap; g++) step_cyc();
        end
        vid.hs_i = 1'b1;
        rise_drv = cyc;
        repeat (24) step_cyc();

        nout = (last * S) / step + 1;
        for (int k = 0; k < nout; k++) begin
            pos = k * step;
            i = pos >> FRAC;
            f = pos % S;
            if (f == 0) v = pix[i];
            else v = (pix[i] * (S - f) + pix[i + 1] * f + RND * (S / 2)) >> FRAC;
            exp_q.push_back(v);
        end

        chk({tag, ".count"}, got.size(), nout);
        for (int k = 0; k < nout && k < got.size(); k++)
            chk($sformatf("%s.pix%0d", tag, k), got[k], exp_q[k]);
        chk({tag, ".latency"}, first_de - drv1, 2);
        chk({tag, ".hs_fall"}, hs_fall - fall_drv, 2);
        rise_exp = (rise_drv + 2 > last_de + 1) ? rise_drv + 2 : last_de + 1;
        chk({tag, ".hs_rise"}, hs_rise, rise_exp);
        chk({tag, ".de_in_blank"}, de_in_blank, 0);
    endtask

    initial begin
        int ramp[$];
        int pl[$];
        int vcyc, st, ls, gp, extra;
        vid.di_i = '0; vid.de_i = 1'b0; vid.hs_i = 1'b1; vid.vs_i = 1'b0;
        h_step = 16'd128; v_step = 16'd0; last_reg = 16'd7;
        for (int i = 0; i < 8; i++) ramp.push_back(i * 10);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.do", int'(vid.do_o), 0);
        chk("reset.de", int'(vid.de_o), 0);
        chk("reset.hs", int'(vid.hs_o), 1);
        chk("reset.vs", int'(vid.vs_o), 0);
        rst_n = 1'b1;
        repeat (2) step_cyc();

        vid.vs_i = 1'b1;
        vcyc = cyc;
        repeat (2) @(negedge clk);
        chk("vs.delay1", int'(vid.vs_o), 0);
        @(negedge clk);
        chk("vs.delay2", int'(vid.vs_o), 1);
        chk("vs.cycle", cyc - vcyc, 2);
        step_cyc();

        run_line(ramp, 128, 7, 1, "unity");
        run_line(ramp, 256, 7, 1, "half");
        run_line(ramp, 192, 7, 1, "s192");
        run_line(ramp, 64, 7, 2, "double");
        pl = '{0, 1};
        run_line(pl, 64, 1, 2, "two_px");

        // Reset in the middle of a line, then let the aborted line run out.
        h_step = 16'd128; last_reg = 16'd7;
        step_cyc();
        vid.hs_i = 1'b0;
        step_cyc();
        for (int i = 0; i < 4; i++) begin
            vid.di_i = PW'(ramp[i]); vid.de_i = 1'b1; step_cyc();
        end
        vid.de_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.de", int'(vid.de_o), 0);
        chk("midrst.hs", int'(vid.hs_o), 1);
        chk("midrst.do", int'(vid.do_o), 0);
        step_cyc();
        step_cyc();
        rst_n = 1'b1;
        got.delete(); hs_fall = -1;
        for (int i = 4; i < 8; i++) begin
            vid.di_i = PW'(ramp[i]); vid.de_i = 1'b1; step_cyc();
        end
        vid.de_i = 1'b0;
        repeat (6) step_cyc();
        chk("midrst.aborted_outputs", got.size(), 0);
        chk("midrst.hs_stays_high", hs_fall, -1);
        vid.hs_i = 1'b1;
        repeat (4) step_cyc();

        run_line(ramp, 128, 7, 1, "frame2_a");
        run_line(ramp, 128, 7, 1, "frame2_b");

        for (int r = 0; r < 6; r++) begin
            pl.delete();
            st = $urandom_range(400, 32);
            ls = $urandom_range(15, 1);
            gp = (S + st - 1) / st;
            extra = $urandom_range(2, 0);
            for (int i = 0; i < ls + 1 + extra; i++) pl.push_back($urandom_range(255, 0));
            run_line(pl, st, ls, gp, $sformatf("rand%0d", r));
        end

        chk("sparse_zero", sparse_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
